uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit data register between NUM_REQ byte-stream requesters, for example the CPU console and a hardware debug/trace source.
- Arbitration is round-robin with line atomicity. A granted requester keeps the UART until it sends an end-of-line byte, reaches a burst limit, or goes idle past a timeout. Output lines from different sources therefore never interleave mid-line.
- Sits between the requesters and the UART's reg_dat_we / reg_dat_di / reg_dat_wait write port.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared widths, default line terminator and arbiter state codes.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;
  localparam int         UART_DATA_W = 8;
  localparam int         UART_REG_W  = 32;
  localparam logic [7:0] DEFAULT_EOL = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    SEND = 2'd2
  } state_e;
endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; searches upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);
  logic w_found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = last;
    w_found   = 1'b0;
    // Offset 1..N wraps back to last itself, so a lone requester is re-picked.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && (i == (int'(last) + k) % N) && req[i]) begin
          w_found     = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = IW'(i);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Line-atomic round-robin sharing of the UART data write port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ      = 2,
  parameter logic [7:0] EOL_CHAR     = DEFAULT_EOL,
  parameter int         BURST_MAX    = 64,
  parameter int         IDLE_TIMEOUT = 255,
  parameter int         GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           uart_dat_we,
  output logic [UART_REG_W-1:0]          uart_dat_di,
  input  logic                           uart_dat_wait,
  output logic                           grant_valid,
  output logic [GW-1:0]                  grant_id
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOCK = LOCK;
  localparam logic [1:0] ST_SEND = SEND;
  // Unlimited bursts still need a counter; it saturates rather than wraps.
  localparam int BW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 8;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [1:0]             r_state;
  logic [GW-1:0]          r_grant_id;
  logic                   r_grant_valid;
  logic [BW-1:0]          r_burst_cnt;
  logic [TW-1:0]          r_idle_cnt;
  logic [UART_DATA_W-1:0] r_byte;
  logic                   r_we;

  logic [NUM_REQ-1:0]     w_pick_oh;
  logic [GW-1:0]          w_pick_idx;
  logic                   w_owner_valid;
  logic [UART_DATA_W-1:0] w_owner_byte;
  logic [BW-1:0]          w_burst_next;
  logic                   w_release;

  rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
    .req       (req_valid),
    .last      (r_grant_id),
    .grant_oh  (w_pick_oh),
    .grant_idx (w_pick_idx)
  );

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_byte  = '0;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_owner_valid = req_valid[i];
        w_owner_byte  = req_data[i*UART_DATA_W +: UART_DATA_W];
        req_ready[i]  = (r_state == ST_LOCK);
      end
    end
  end

  assign w_burst_next = (r_burst_cnt == '1) ? r_burst_cnt : r_burst_cnt + 1'b1;
  assign w_release    = (r_byte == EOL_CHAR) ||
                        ((BURST_MAX != 0) && (r_burst_cnt == BW'(BURST_MAX)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_grant_id    <= GW'(NUM_REQ - 1);
      r_grant_valid <= 1'b0;
      r_burst_cnt   <= '0;
      r_idle_cnt    <= '0;
      r_byte        <= '0;
      r_we          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pick_oh) begin
            r_grant_id    <= w_pick_idx;
            r_grant_valid <= 1'b1;
            r_burst_cnt   <= '0;
            r_idle_cnt    <= '0;
            r_state       <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_owner_valid) begin
            r_byte      <= w_owner_byte;
            r_burst_cnt <= w_burst_next;
            r_we        <= 1'b1;
            r_state     <= ST_SEND;
          end else if (r_idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
            r_grant_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (!uart_dat_wait) begin
            r_we <= 1'b0;
            if (w_release) begin
              r_grant_valid <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_idle_cnt <= '0;
              r_state    <= ST_LOCK;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_dat_we = r_we;
  assign uart_dat_di = {{(UART_REG_W - UART_DATA_W){1'b0}}, r_byte};
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed vector table plus sequences for the arbiter corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  logic        clk;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic        grant_valid;
  logic [0:0]  grant_id;

  logic        auto_mode;
  logic [1:0]  man_valid, auto_valid;
  logic [7:0]  man_d0, man_d1, auto_d0, auto_d1;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  log_q[$];
  logic        ready_viol;
  int          checks, failures;

  assign req_valid = auto_mode ? auto_valid : man_valid;
  assign req_data  = auto_mode ? {auto_d1, auto_d0} : {man_d1, man_d0};

  uart_tx_arbiter #(
    .NUM_REQ(2), .EOL_CHAR(8'h0A), .BURST_MAX(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
    .uart_dat_wait(uart_dat_wait), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue-fed requesters: a byte leaves its queue when valid&ready ahead of the edge.
  always @(negedge clk) begin
    auto_valid[0] = (q0.size() > 0);
    auto_valid[1] = (q1.size() > 0);
    auto_d0 = (q0.size() > 0) ? q0[0] : 8'h00;
    auto_d1 = (q1.size() > 0) ? q1[0] : 8'h00;
    #1;
    if (auto_mode && resetn) begin
      if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
      if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (resetn && uart_dat_we && !uart_dat_wait) log_q.push_back(uart_dat_di[7:0]);
    for (int i = 0; i < 2; i++)
      if (req_ready[i] && !(grant_valid && (int'(grant_id) == i))) ready_viol = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    log_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int c = 0; c < budget && log_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
  endtask

  typedef struct packed {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       stall;
    logic [1:0] ready;
    logic       we;
    logic [7:0] di;
    logic       gv;
    logic       gid;
  } vec_t;

  vec_t vecs[15];

  initial begin
    checks = 0; failures = 0; ready_viol = 1'b0;
    auto_mode = 1'b0; man_valid = '0; man_d0 = '0; man_d1 = '0;
    auto_valid = '0; auto_d0 = '0; auto_d1 = '0;
    uart_dat_wait = 1'b0; resetn = 1'b0;

    // Single byte from r0, then r0 idles out while r1 waits; r1 is granted next.
    //            valid  d0     d1     stl  rdy    we    di     gv    gid
    vecs[0]  = '{2'b01, 8'h41, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 8'h41, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 8'h41, 1'b1, 1'b0};
    for (int i = 3; i <= 10; i++)
      vecs[i] = '{2'b10, 8'h00, 8'h5A, 1'b0, 2'b01, 1'b0, 8'h41, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 8'h00, 8'h5A, 1'b0, 2'b00, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[12] = '{2'b10, 8'h00, 8'h5A, 1'b0, 2'b10, 1'b0, 8'h41, 1'b1, 1'b1};
    vecs[13] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[14] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'h5A, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      man_valid = vecs[i].valid; man_d0 = vecs[i].d0; man_d1 = vecs[i].d1;
      uart_dat_wait = vecs[i].stall;
      #1;
      check($sformatf("vec%0d{rdy,we,di,gv,gid}", i),
            {19'h0, req_ready, uart_dat_we, uart_dat_di[7:0], grant_valid, grant_id},
            {19'h0, vecs[i].ready, vecs[i].we, vecs[i].di, vecs[i].gv, vecs[i].gid});
      check($sformatf("vec%0d_di_upper", i), {8'h0, uart_dat_di[31:8]}, 32'h0);
      @(negedge clk);
    end
    man_valid = '0;

    // Line atomicity with both requesters valid from reset.
    resetn = 1'b0; auto_mode = 1'b1;
    q0 = '{8'h41, 8'h42, 8'h0A};
    q1 = '{8'h78, 8'h79, 8'h0A};
    do_reset();
    wait_log(6, 200);
    check_log("line_order", '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A});

    // Burst limit of 4; r1's line ends on EOL exactly at the burst limit.
    resetn = 1'b0;
    q0 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    q1 = '{8'h78, 8'h79, 8'h7A, 8'h0A};
    do_reset();
    wait_log(14, 400);
    check_log("burst_order", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h78, 8'h79, 8'h7A, 8'h0A,
                               8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19});

    // Stall: write request and data hold steady for 20 stalled cycles.
    begin
      logic stable, rdy_zero;
      int   c;
      resetn = 1'b0; uart_dat_wait = 1'b1;
      q0 = '{8'h55}; q1.delete();
      do_reset();
      for (c = 0; c < 20 && !uart_dat_we; c++) @(negedge clk);
      check("stall_we_seen", {31'h0, uart_dat_we}, 32'h1);
      stable = 1'b1; rdy_zero = 1'b1;
      repeat (20) begin
        @(negedge clk); #1;
        if (!(uart_dat_we && uart_dat_di == 32'h55)) stable = 1'b0;
        if (req_ready != 2'b00) rdy_zero = 1'b0;
      end
      check("stall_hold", {31'h0, stable}, 32'h1);
      check("stall_ready_zero", {31'h0, rdy_zero}, 32'h1);
      check("stall_no_write", log_q.size(), 0);
      @(negedge clk); uart_dat_wait = 1'b0;
      repeat (4) @(negedge clk);
      check_log("stall_single", '{8'h55});
    end

    // Asynchronous reset while a write is pending.
    begin
      int c;
      resetn = 1'b0; auto_mode = 1'b0; uart_dat_wait = 1'b1;
      man_valid = 2'b01; man_d0 = 8'h33; man_d1 = 8'h66;
      do_reset();
      for (c = 0; c < 20 && !uart_dat_we; c++) begin @(negedge clk); #1; end
      check("arst_we_before", {31'h0, uart_dat_we}, 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("arst_we", {31'h0, uart_dat_we}, 32'h0);
      check("arst_gv", {31'h0, grant_valid}, 32'h0);
      check("arst_ready", {30'h0, req_ready}, 32'h0);
      check("arst_di", uart_dat_di, 32'h0);
      man_valid = 2'b11; uart_dat_wait = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk); #1;
      check("arst_regrant{gv,gid}", {30'h0, grant_valid, grant_id}, 32'h2);
      check("arst_no_retry", log_q.size(), 0);
    end

    check("nonowner_ready", {31'h0, ready_viol}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
